// File: rtl/drop32_mem_arb.sv
// rtl/drop32_mem_arb.sv - round-robin two-port arbiter for the drop32 single-port RAM
module drop32_mem_arb #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_p0_req,
   input  logic            i_p0_we,
   input  logic [AW-1:0]   i_p0_addr,
   input  logic [DW-1:0]   i_p0_wdata,
   input  logic [DW/8-1:0] i_p0_be,
   output logic            o_p0_gnt,
   output logic            o_p0_rvalid,
   output logic [DW-1:0]   o_p0_rdata,
   input  logic            i_p1_req,
   input  logic            i_p1_we,
   input  logic [AW-1:0]   i_p1_addr,
   input  logic [DW-1:0]   i_p1_wdata,
   input  logic [DW/8-1:0] i_p1_be,
   output logic            o_p1_gnt,
   output logic            o_p1_rvalid,
   output logic [DW-1:0]   o_p1_rdata,
   output logic            o_mem_en,
   output logic            o_mem_we,
   output logic [AW-1:0]   o_mem_addr,
   output logic [DW-1:0]   o_mem_wdata,
   output logic [DW/8-1:0] o_mem_be,
   input  logic [DW-1:0]   i_mem_rdata,
   output logic            o_busy
);

   localparam int BW = DW / 8;
   localparam int CW = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            ptr_q, ptr_d;        // port granted most recently
   logic            owner_q, owner_d;    // port owning the in-flight transaction
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [BW-1:0]   be_q, be_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            rvalid_q, rvalid_d;
   logic            mem_en;

   // State and command registers; reset abandons any in-flight transaction
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= 1'b1;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Arbitration in IDLE, one-cycle ACCESS strobe, latency countdown in WAIT
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            // On a tie the port not granted last wins
            if (i_p0_req && (!i_p1_req || ptr_q)) begin
               owner_d = 1'b0;
               ptr_d   = 1'b0;
               we_d    = i_p0_we;
               addr_d  = i_p0_addr;
               wdata_d = i_p0_wdata;
               be_d    = i_p0_be;
               state_d = S_ACCESS;
            end else if (i_p1_req) begin
               owner_d = 1'b1;
               ptr_d   = 1'b1;
               we_d    = i_p1_we;
               addr_d  = i_p1_addr;
               wdata_d = i_p1_wdata;
               be_d    = i_p1_be;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            cnt_d   = CW'(MEM_LAT);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Count of 1 marks the cycle memory data is valid; exit before wrapping
            if (cnt_q == CW'(1)) begin
               cnt_d    = '0;
               rvalid_d = 1'b1;
               state_d  = S_IDLE;
               if (!we_q) begin
                  rdata_d = i_mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_en      = (state_q == S_ACCESS);
   assign o_mem_en    = mem_en;
   assign o_mem_we    = mem_en & we_q;
   assign o_mem_addr  = mem_en ? addr_q  : '0;
   assign o_mem_wdata = mem_en ? wdata_q : '0;
   assign o_mem_be    = mem_en ? be_q    : '0;

   assign o_p0_gnt    = mem_en & ~owner_q;
   assign o_p1_gnt    = mem_en &  owner_q;
   assign o_p0_rvalid = rvalid_q & ~owner_q;
   assign o_p1_rvalid = rvalid_q &  owner_q;
   assign o_p0_rdata  = rdata_q;
   assign o_p1_rdata  = rdata_q;
   assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_drop32_mem_arb.sv
// tb/tb_drop32_mem_arb.sv - directed self-checking bench for drop32_mem_arb
module tb_drop32_mem_arb;

   logic        clk;
   logic        rst_n;
   logic        seed;

   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [3:0]  p0_be, p1_be;
   logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_en, mem_we, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   logic [31:0] mem [0:63];
   logic [31:0] rd_pipe0, rd_pipe1;

   logic        l1_req, l1_gnt, l1_rvalid, l1_p1_gnt, l1_p1_rvalid;
   logic        l1_en, l1_we, l1_busy;
   logic [31:0] l1_rdata, l1_p1_rdata, l1_addr, l1_wdata;
   logic [3:0]  l1_be;
   logic        l8_req, l8_gnt, l8_rvalid, l8_p1_gnt, l8_p1_rvalid;
   logic        l8_en, l8_we, l8_busy;
   logic [31:0] l8_rdata, l8_p1_rdata, l8_addr, l8_wdata;
   logic [3:0]  l8_be;

   int vectors;
   int miscompares;

   drop32_mem_arb #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
      .i_clk(clk), .i_rst(rst_n),
      .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_be(p0_be),
      .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata),
      .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_be(p1_be),
      .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
      .i_mem_rdata(mem_rdata), .o_busy(busy)
   );

   drop32_mem_arb #(.AW(32), .DW(32), .MEM_LAT(1)) dut_l1 (
      .i_clk(clk), .i_rst(rst_n),
      .i_p0_req(l1_req), .i_p0_we(1'b0), .i_p0_addr(32'h40), .i_p0_wdata(32'h0), .i_p0_be(4'hf),
      .o_p0_gnt(l1_gnt), .o_p0_rvalid(l1_rvalid), .o_p0_rdata(l1_rdata),
      .i_p1_req(1'b0), .i_p1_we(1'b0), .i_p1_addr(32'h0), .i_p1_wdata(32'h0), .i_p1_be(4'h0),
      .o_p1_gnt(l1_p1_gnt), .o_p1_rvalid(l1_p1_rvalid), .o_p1_rdata(l1_p1_rdata),
      .o_mem_en(l1_en), .o_mem_we(l1_we), .o_mem_addr(l1_addr), .o_mem_wdata(l1_wdata), .o_mem_be(l1_be),
      .i_mem_rdata(32'hCAFE0001), .o_busy(l1_busy)
   );

   drop32_mem_arb #(.AW(32), .DW(32), .MEM_LAT(8)) dut_l8 (
      .i_clk(clk), .i_rst(rst_n),
      .i_p0_req(l8_req), .i_p0_we(1'b0), .i_p0_addr(32'h80), .i_p0_wdata(32'h0), .i_p0_be(4'hf),
      .o_p0_gnt(l8_gnt), .o_p0_rvalid(l8_rvalid), .o_p0_rdata(l8_rdata),
      .i_p1_req(1'b0), .i_p1_we(1'b0), .i_p1_addr(32'h0), .i_p1_wdata(32'h0), .i_p1_be(4'h0),
      .o_p1_gnt(l8_p1_gnt), .o_p1_rvalid(l8_p1_rvalid), .o_p1_rdata(l8_p1_rdata),
      .o_mem_en(l8_en), .o_mem_we(l8_we), .o_mem_addr(l8_addr), .o_mem_wdata(l8_wdata), .o_mem_be(l8_be),
      .i_mem_rdata(32'hCAFE0008), .o_busy(l8_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model for the MEM_LAT=2 instance: two-stage read pipeline, byte-enabled writes
   always @(posedge clk) begin
      if (seed) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[4] <= 32'hDEADBEEF;
         mem[8] <= 32'hAABBCCDD;
         rd_pipe0 <= 32'h0;
         rd_pipe1 <= 32'h0;
      end else begin
         rd_pipe1 <= rd_pipe0;
         rd_pipe0 <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : 32'h0;
         if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end
   assign mem_rdata = rd_pipe1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int k1, k8;
      logic [31:0] r1, r8;
      vectors = 0;
      miscompares = 0;
      seed = 1'b1;
      rst_n = 1'b0;
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
      l1_req = 0; l8_req = 0;
      #2;
      chk("reset_busy", {31'b0, busy}, 32'h0);
      chk("reset_mem_en", {31'b0, mem_en}, 32'h0);
      chk("reset_rdata", p0_rdata, 32'h0);
      tick();
      tick();
      seed = 1'b0;
      rst_n = 1'b1;
      tick();

      // p0 read of 0x10
      p0_req = 1; p0_we = 0; p0_addr = 32'h10; p0_be = 4'hf;
      chk("rd_idle_busy", {31'b0, busy}, 32'h0);
      tick();
      chk("rd_mem_en", {31'b0, mem_en}, 32'h1);
      chk("rd_p0_gnt", {31'b0, p0_gnt}, 32'h1);
      chk("rd_p1_gnt", {31'b0, p1_gnt}, 32'h0);
      chk("rd_mem_addr", mem_addr, 32'h10);
      chk("rd_mem_we", {31'b0, mem_we}, 32'h0);
      p0_req = 0;
      tick();
      chk("rd_wait_en", {31'b0, mem_en}, 32'h0);
      chk("rd_wait_addr0", mem_addr, 32'h0);
      chk("rd_wait_busy", {31'b0, busy}, 32'h1);
      tick();
      chk("rd_no_early_rvalid", {31'b0, p0_rvalid}, 32'h0);
      tick();
      chk("rd_p0_rvalid", {31'b0, p0_rvalid}, 32'h1);
      chk("rd_p1_rvalid", {31'b0, p1_rvalid}, 32'h0);
      chk("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
      chk("rd_resp_busy", {31'b0, busy}, 32'h0);
      tick();
      chk("rd_rvalid_pulse", {31'b0, p0_rvalid}, 32'h0);

      // p1 write 0x20, partial byte enables
      p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h12345678; p1_be = 4'b0011;
      tick();
      chk("wr_p1_gnt", {31'b0, p1_gnt}, 32'h1);
      chk("wr_p0_gnt", {31'b0, p0_gnt}, 32'h0);
      chk("wr_mem_we", {31'b0, mem_we}, 32'h1);
      chk("wr_mem_addr", mem_addr, 32'h20);
      chk("wr_mem_wdata", mem_wdata, 32'h12345678);
      chk("wr_mem_be", {28'b0, mem_be}, 32'h3);
      p1_req = 0;
      tick();
      chk("wr_wait_we0", {31'b0, mem_we}, 32'h0);
      tick();
      tick();
      chk("wr_p1_rvalid", {31'b0, p1_rvalid}, 32'h1);
      chk("wr_p1_rdata_kept", p1_rdata, 32'hDEADBEEF);

      // both ports requesting continuously: strict alternation starting at p0
      p0_req = 1; p0_we = 0; p0_addr = 32'h10;
      p1_req = 1; p1_we = 0; p1_addr = 32'h20;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("rr_p0_gnt_%0d", i), {31'b0, p0_gnt}, (i % 2 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("rr_p1_gnt_%0d", i), {31'b0, p1_gnt}, (i % 2 == 1) ? 32'h1 : 32'h0);
         tick();
         tick();
         tick();
         chk($sformatf("rr_p0_rvalid_%0d", i), {31'b0, p0_rvalid}, (i % 2 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("rr_p1_rvalid_%0d", i), {31'b0, p1_rvalid}, (i % 2 == 1) ? 32'h1 : 32'h0);
         chk($sformatf("rr_rdata_%0d", i), p0_rdata, (i % 2 == 0) ? 32'hDEADBEEF : 32'hAABB5678);
         if (i == 5) begin
            p0_req = 0;
            p1_req = 0;
         end
      end
      tick();
      chk("rr_quiet", {31'b0, busy}, 32'h0);

      // p0 re-requests in its own rvalid cycle
      p0_req = 1;
      tick();
      chk("b2b_gnt_a", {31'b0, p0_gnt}, 32'h1);
      tick();
      tick();
      tick();
      chk("b2b_rvalid_a", {31'b0, p0_rvalid}, 32'h1);
      tick();
      chk("b2b_gnt_b", {31'b0, p0_gnt}, 32'h1);
      p0_req = 0;
      tick();
      tick();
      tick();
      chk("b2b_rvalid_b", {31'b0, p0_rvalid}, 32'h1);
      tick();

      // reset during WAIT after a p0 grant (pointer would otherwise favour p1)
      p0_req = 1;
      tick();
      chk("rst_pre_gnt", {31'b0, p0_gnt}, 32'h1);
      p0_req = 0;
      tick();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_busy", {31'b0, busy}, 32'h0);
      chk("rst_async_rdata", p0_rdata, 32'h0);
      chk("rst_async_p1rdata", p1_rdata, 32'h0);
      chk("rst_async_en", {31'b0, mem_en}, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("rst_no_rvalid_%0d", i), {30'b0, p1_rvalid, p0_rvalid}, 32'h0);
         chk($sformatf("rst_idle_%0d", i), {31'b0, busy}, 32'h0);
      end
      p0_req = 1;
      p1_req = 1;
      tick();
      chk("rst_tie_p0", {31'b0, p0_gnt}, 32'h1);
      chk("rst_tie_p1", {31'b0, p1_gnt}, 32'h0);
      p0_req = 0;
      p1_req = 0;
      for (int i = 0; i < 4; i++) tick();

      // MEM_LAT = 1 and 8 instances: request-to-rvalid distance
      k1 = 0; k8 = 0; r1 = 32'h0; r8 = 32'h0;
      l1_req = 1;
      l8_req = 1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (l1_gnt) l1_req = 0;
         if (l8_gnt) l8_req = 0;
         if (l1_rvalid && k1 == 0) begin k1 = k; r1 = l1_rdata; end
         if (l8_rvalid && k8 == 0) begin k8 = k; r8 = l8_rdata; end
      end
      chk("lat1_cycles", k1, 32'd3);
      chk("lat8_cycles", k8, 32'd10);
      chk("lat1_rdata", r1, 32'hCAFE0001);
      chk("lat8_rdata", r8, 32'hCAFE0008);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/drop32_mem_arb.md
# drop32_mem_arb

Two-port memory arbiter for the drop32 SoC. It shares one single-port synchronous memory (boot/data RAM) between the core's instruction-fetch port (port 0) and load/store port (port 1). Arbitration is round-robin, one transaction is in flight at a time, and each request is acknowledged with a grant pulse and later completed with a response pulse. It sits between the drop32 core and the SoC RAM inside drop32soc.

## Interface
Parameters:
- AW, 32, address width.
- DW, 32, data width; byte enables are DW/8 bits.
- MEM_LAT, 1, cycles from the memory enable cycle to valid i_mem_rdata; legal range 1..8.

Ports (p = 0, 1):
- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_pN_req  in  1  port p request; held with its fields until o_pN_gnt.
- i_pN_we  in  1  1 = write, 0 = read.
- i_pN_addr  in  AW  byte address, passed through unmodified.
- i_pN_wdata  in  DW  write data.
- i_pN_be  in  DW/8  byte enables.
- o_pN_gnt  out  1  one-cycle accept pulse.
- o_pN_rvalid  out  1  one-cycle completion pulse; reads and writes both complete this way.
- o_pN_rdata  out  DW  read data, valid with o_pN_rvalid.
- o_mem_en, o_mem_we  out  1  memory strobe and write select.
- o_mem_addr  out  AW; o_mem_wdata  out  DW; o_mem_be  out  DW/8  memory command.
- i_mem_rdata  in  DW  memory read data.
- o_busy  out  1  high in ACCESS and WAIT.

## Operation
- FSM states: IDLE, ACCESS, WAIT. Command registers: we, addr, wdata, be, and owner (1 bit).
- IDLE:
  - No request: stay in IDLE.
  - One requester: that port wins.
  - Both requesting: the port not granted last wins. The last-grant pointer resets to 1, so port 0 wins the first tie.
  - On a win: latch the winner's command and owner, update the pointer, go to ACCESS.
- ACCESS, exactly one cycle:
  - o_mem_en = 1, driving the latched command.
  - o_pN_gnt[owner] = 1.
  - Load latency counter with MEM_LAT. Counter width is clog2(MEM_LAT+1); it never wraps.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reads 1, i_mem_rdata is valid. On that edge:
    - For reads, capture it into the rdata register.
    - Set the rvalid register for owner.
    - Go to IDLE.
- Response cycle, which is IDLE:
  - o_pN_rvalid[owner] = 1.
  - o_p0_rdata and o_p1_rdata both drive the shared rdata register.
  - Writes do not modify the rdata register.
  - Arbitration runs in this same cycle. The port just completed may request again and competes normally.
- Requests raised during ACCESS or WAIT wait, unserviced, until IDLE; they are not lost.
- A request dropped before its grant is simply not considered. Changing command fields while requesting before grant is a requester protocol violation; behaviour is unspecified.
- o_mem_we, o_mem_addr, o_mem_wdata and o_mem_be are zero whenever o_mem_en = 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = IDLE, pointer = 1, counter = 0, rdata register = 0.
  - All outputs 0.
  - An in-flight transaction is abandoned: no gnt or rvalid is issued afterwards.
- Request seen in IDLE at cycle T: ACCESS (o_mem_en, gnt) at T+1.
- Memory data valid at T+1+MEM_LAT.
- o_pN_rvalid at T+2+MEM_LAT.
- Next ACCESS no earlier than T+3+MEM_LAT. Peak throughput is one transaction per MEM_LAT+2 cycles.
- gnt and rvalid are single-cycle pulses and never asserted for both ports in the same cycle.
- With both ports requesting continuously, grants strictly alternate 0,1,0,1. Worst-case wait for a port is 2*(MEM_LAT+2) cycles.

## Test plan
- MEM_LAT=2, read on p0 (addr 0x10; memory model returns 0xDEADBEEF), req at cycle 5:
  - o_mem_en and o_p0_gnt at cycle 6.
  - o_p0_rvalid with o_p0_rdata = 0xDEADBEEF at cycle 9.
  - No p1 pulses.
- p1 write (addr 0x20, wdata 0x12345678, be 4'b0011):
  - One o_mem_en cycle with o_mem_we = 1 and those exact fields.
  - o_p1_rvalid pulse after MEM_LAT+1 more cycles.
  - o_p1_rdata still equals the prior read value.
- Both ports request continuously for 6 transactions:
  - Grant order 0,1,0,1,0,1.
  - Each gnt spaced MEM_LAT+2 cycles apart; rvalid owner matches gnt owner.
- p0 requests again in its rvalid cycle while p1 is idle:
  - p0 granted the next cycle; back-to-back at MEM_LAT+2 cycle spacing.
- Pull i_rst low mid-WAIT:
  - All outputs 0 immediately, with no clock edge needed.
  - After release with no requests: no rvalid and o_busy = 0.
  - A next tie goes to p0.
- MEM_LAT=1 and MEM_LAT=8 builds, single read each:
  - rvalid exactly 3 and 10 cycles after the request cycle.
